uart_tx_queue: RTL and testbench
================================

Name: uart_tx_queue

Overview:
- Byte FIFO plus issue FSM placed directly upstream of the UART transmit controller (9600 baud, 100 MHz CLK).
- Accepts bytes from any producer, such as a command/response formatter or debug printer, through a valid/ready interface.
- Drains bytes one at a time into the transmitter using its single-cycle send strobe, its byte input and its ready output.
- Lets producers burst up to DEPTH bytes without waiting roughly 1.04 ms per character.

Parameters:
- DEPTH_LOG2, 4: FIFO depth = 2**DEPTH_LOG2 entries (16). Legal range 2..8.
- DATA_W, 8: byte width. Fixed at 8 to match the transmitter byte input.

Ports:
- CLK  in  1  system clock, 100 MHz.
- RST_N  in  1  asynchronous active-low reset.
- wr_valid  in  1  producer has a byte.
- wr_data  in  8  producer byte.
- wr_ready  out  1  = !full. Write accepted on a CLK edge when wr_valid && wr_ready.
- tx_ready  in  1  transmitter ready (high only in its RDY state).
- tx_send  out  1  one-cycle send strobe to the transmitter.
- tx_data  out  8  byte to the transmitter; valid whenever tx_send=1.
- empty  out  1  FIFO count == 0.
- full  out  1  FIFO count == DEPTH.
- idle  out  1  empty && FSM in IDLE && tx_ready.

Behaviour:
- Reset (async assert, sync release; RST_N held low >= 2 CLK):
  - tx_send=0, tx_data=8'h00, rd/wr pointers=0, count=0.
  - empty=1, full=0, wr_ready=1, FSM=IDLE.
  - A byte already latched by the transmitter finishes on the line. The FSM only issues after tx_ready is seen high.
- FIFO:
  - Circular RAM of DEPTH x 8. Pointers are DEPTH_LOG2 bits and wrap DEPTH-1 -> 0. count is DEPTH_LOG2+1 bits.
  - Write increments wr_ptr and count. Pop increments rd_ptr and decrements count.
  - Simultaneous write and pop: count unchanged, both pointers advance.
  - wr_ready is !full only. No write-through-when-full, even if a pop occurs in the same cycle.
  - No bypass. A byte is readable the cycle after it is written.
- FSM, all outputs registered:
  - IDLE: if !empty && tx_ready, then at the edge: tx_send<=1, tx_data<=mem[rd_ptr], pop, go to ISSUE. Otherwise stay.
  - ISSUE (tx_send=1 for exactly this cycle): at the edge, tx_send<=0, go to WAIT_BUSY. tx_data is held until the next issue.
  - WAIT_BUSY: wait for tx_ready==0 (the transmitter leaves RDY), then go to WAIT_DONE. This guards against re-issuing while a stale tx_ready is high.
  - WAIT_DONE: wait for tx_ready==1, then go to IDLE.
  - Illegal encoding: go to IDLE, tx_send<=0.
- Latency and throughput:
  - Write at edge E0 with queue empty and transmitter idle: tx_send is high in the cycle after E1.
  - Back-to-back bytes: the next tx_send occurs no sooner than 2 CLK after tx_ready returns high.
- Writes may arrive in any FSM state. Pops occur only on the IDLE->ISSUE transition.
- Write while empty and full are both impossible together (DEPTH >= 4).

Optional Feature:
- Macro UART_TX_QUEUE_LEVEL_EN.
- Defined:
  - Adds output port level [DEPTH_LOG2:0], equal to the registered count.
  - Adds output port ovf_sticky (1 bit). It sets when wr_valid && full on an edge, and clears only on reset.
- Undefined: neither port exists and no sticky logic is built. Core behaviour is identical.

Test Plan:
- Reset then idle:
  - Stimulus: RST_N low for 3 cycles, tx_ready=1.
  - Response: empty=1, full=0, wr_ready=1, tx_send=0, idle=1. No strobe for 100 cycles.
- Single byte:
  - Stimulus: write 8'hA5. Behavioural model of the transmitter drops tx_ready the cycle after it samples the strobe and holds it low 10*10417 cycles.
  - Response: exactly one tx_send pulse, 1 cycle wide, with tx_data=8'hA5. Then empty=1, and idle=1 after the frame.
- Fill to full:
  - Stimulus: tx_ready=0, write 17 bytes 8'h00..8'h10.
  - Response: first 16 accepted, full=1 and wr_ready=0 after the 16th. 8'h10 is not accepted. ovf_sticky=1 if the macro is enabled.
- Drain order with wrap:
  - Stimulus: release tx_ready with the model transmitter (frame shortened to 20 cycles), writing 8 more bytes mid-drain.
  - Response: 24 strobes, data in strict FIFO order across the pointer wrap. No double strobe per tx_ready low period.
- Simultaneous write and pop at full:
  - Stimulus: full queue, IDLE, tx_ready=1, wr_valid=1.
  - Response: write refused (wr_ready=0). After the pop, full=0 and count=15. The next write is accepted.
- Reset mid-drain:
  - Stimulus: RST_N low during WAIT_DONE with 5 bytes queued.
  - Response: queue empty, tx_send=0. After release, no strobe until a new write and tx_ready=1.

Source files
------------

// File: rtl/uart_tx_queue_if.sv
// -----------------------------------------------------------------------------
// uart_tx_queue_if
//
// Purpose:
//   Bundles the two handshakes of the UART transmit queue:
//     * the producer side (valid/ready byte write), and
//     * the transmitter side (single-cycle send strobe, byte, ready).
//
// Signals:
//   wr_valid  producer has a byte
//   wr_data   producer byte
//   wr_ready  queue can accept a byte this cycle (= !full)
//   tx_ready  transmitter is in its ready state
//   tx_send   one-cycle send strobe to the transmitter
//   tx_data   byte to the transmitter, valid whenever tx_send is high
//
// Modports:
//   slave   the queue's view (consumes writes, drives the transmitter)
//   master  the environment's view (producer plus transmitter)
// -----------------------------------------------------------------------------
interface uart_tx_queue_if #(
    parameter int DATA_W = 8
);
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              tx_ready;
    logic              tx_send;
    logic [DATA_W-1:0] tx_data;

    modport slave (
        input  wr_valid,
        input  wr_data,
        input  tx_ready,
        output wr_ready,
        output tx_send,
        output tx_data
    );

    modport master (
        output wr_valid,
        output wr_data,
        output tx_ready,
        input  wr_ready,
        input  tx_send,
        input  tx_data
    );
endinterface

// File: rtl/uart_tx_queue.sv
// -----------------------------------------------------------------------------
// uart_tx_queue
//
// Purpose:
//   Byte FIFO plus issue FSM sitting directly in front of the UART transmit
//   controller. Producers burst up to 2**DEPTH_LOG2 bytes without waiting for
//   each character to go out on the line; the FSM drains the FIFO one byte at
//   a time using the transmitter's single-cycle send strobe and its ready
//   output.
//
// Parameters:
//   DEPTH_LOG2  FIFO depth is 2**DEPTH_LOG2 entries (legal range 2..8)
//   DATA_W      byte width, fixed at 8 to match the transmitter
//
// Ports:
//   CLK         system clock
//   RST_N       asynchronous active-low reset
//   bus         uart_tx_queue_if.slave (wr_valid/wr_data/wr_ready,
//               tx_ready/tx_send/tx_data)
//   empty       FIFO holds no bytes
//   full        FIFO holds DEPTH bytes
//   idle        empty, FSM in IDLE and transmitter ready
//
// Optional build (macro UART_TX_QUEUE_LEVEL_EN):
//   level       registered FIFO occupancy, DEPTH_LOG2+1 bits
//   ovf_sticky  set when a write is offered while full; cleared only by reset
//   With the macro undefined neither port nor the sticky logic exists and
//   the core behaviour is unchanged.
// -----------------------------------------------------------------------------
module uart_tx_queue #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    uart_tx_queue_if.slave        bus,
    output logic                  empty,
    output logic                  full,
    output logic                  idle
`ifdef UART_TX_QUEUE_LEVEL_EN
    ,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  ovf_sticky
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Count value meaning "every entry occupied": MSB set, rest clear.
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Storage and bookkeeping
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [DEPTH_LOG2:0]   count_reg;

    state_t                state_reg;
    logic                  tx_send_reg;
    logic [DATA_W-1:0]     tx_data_reg;

    logic                  push;
    logic                  pop;

    // Status derived from the registered count only, so a byte written at an
    // edge becomes visible to the FSM on the following edge (no bypass).
    assign empty = (count_reg == '0);
    assign full  = (count_reg == FULL_COUNT);

    // Full refuses writes even if a pop happens in the same cycle; this keeps
    // wr_ready a pure function of registered state.
    assign bus.wr_ready = !full;
    assign push         = bus.wr_valid && !full;

    // The only pop point: IDLE with data available and the transmitter ready.
    assign pop = (state_reg == ST_IDLE) && !empty && bus.tx_ready;

    assign bus.tx_send = tx_send_reg;
    assign bus.tx_data = tx_data_reg;

    assign idle = empty && (state_reg == ST_IDLE) && bus.tx_ready;

    // -------------------------------------------------------------------------
    // FIFO RAM: write port only; the read is registered inside the FSM so the
    // array maps onto a block RAM with an output register.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr_reg] <= bus.wr_data;
        end
    end

    // -------------------------------------------------------------------------
    // Pointers and occupancy. Pointers are exactly DEPTH_LOG2 bits wide, so
    // the increment wraps DEPTH-1 -> 0 on its own.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Issue FSM. All outputs are registered here.
    //
    // After issuing, the FSM first waits for tx_ready to fall (the transmitter
    // has accepted the byte and left its ready state) and only then for it to
    // rise again. Skipping the first wait could let a stale high tx_ready
    // trigger a second strobe before the transmitter has reacted.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg   <= ST_IDLE;
            tx_send_reg <= 1'b0;
            tx_data_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    tx_send_reg <= 1'b0;
                    if (pop) begin
                        tx_send_reg <= 1'b1;
                        tx_data_reg <= mem[rd_ptr_reg];
                        state_reg   <= ST_ISSUE;
                    end
                end

                // Strobe is high for exactly this one cycle; tx_data keeps
                // the issued byte until the next issue.
                ST_ISSUE: begin
                    tx_send_reg <= 1'b0;
                    state_reg   <= ST_WAIT_BUSY;
                end

                ST_WAIT_BUSY: begin
                    tx_send_reg <= 1'b0;
                    if (!bus.tx_ready) begin
                        state_reg <= ST_WAIT_DONE;
                    end
                end

                ST_WAIT_DONE: begin
                    tx_send_reg <= 1'b0;
                    if (bus.tx_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end

                default: begin
                    tx_send_reg <= 1'b0;
                    state_reg   <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef UART_TX_QUEUE_LEVEL_EN
    // -------------------------------------------------------------------------
    // Occupancy and overflow reporting. The sticky flag records any write
    // offered while full, i.e. a byte the producer lost.
    // -------------------------------------------------------------------------
    logic ovf_sticky_reg;

    assign level      = count_reg;
    assign ovf_sticky = ovf_sticky_reg;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ovf_sticky_reg <= 1'b0;
        end else if (bus.wr_valid && full) begin
            ovf_sticky_reg <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_queue
//
// Directed bench for uart_tx_queue. A behavioural transmitter model drives
// tx_ready: it drops ready the cycle after it samples a strobe and holds it
// low for frame_len cycles (or simply follows force_val when model_en is 0).
// Every strobe is logged with its data byte; strobe-width and
// strobe-while-busy violations are counted for later checks.
// -----------------------------------------------------------------------------
module tb_uart_tx_queue;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    logic empty;
    logic full;
    logic idle;
`ifdef UART_TX_QUEUE_LEVEL_EN
    logic [4:0] level;
    logic       ovf_sticky;
`endif

    uart_tx_queue_if #(.DATA_W(8)) bus ();

    uart_tx_queue #(
        .DEPTH_LOG2(4),
        .DATA_W    (8)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .bus       (bus),
        .empty     (empty),
        .full      (full),
        .idle      (idle)
`ifdef UART_TX_QUEUE_LEVEL_EN
        ,
        .level     (level),
        .ovf_sticky(ovf_sticky)
`endif
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Transmitter model controls
    bit         model_en  = 1'b0;
    bit         force_val = 1'b1;
    int         frame_len = 20;
    int         busy_cnt  = 0;
    logic [7:0] log_q[$];
    int         width_err = 0;
    int         dbl_err   = 0;

    initial begin : tx_model
        bit sent;
        bit rdy_s;
        bit prev_sent;
        prev_sent    = 1'b0;
        bus.tx_ready = 1'b1;
        forever begin
            @(posedge CLK);
            sent  = bus.tx_send;
            rdy_s = bus.tx_ready;
            if (sent) begin
                log_q.push_back(bus.tx_data);
                $display("strobe #%0d data=%02h t=%0t", log_q.size(), bus.tx_data, $time);
                if (prev_sent) width_err++;
                if (!rdy_s)    dbl_err++;
            end
            prev_sent = sent;
            #1;
            if (!model_en) begin
                bus.tx_ready = force_val;
                busy_cnt     = 0;
            end else if (sent) begin
                bus.tx_ready = 1'b0;
                busy_cnt     = frame_len;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                bus.tx_ready = 1'b0;
            end else begin
                bus.tx_ready = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Called at a negedge: offers one byte across the next posedge.
    task automatic drive_wr(input logic [7:0] d, output bit acc);
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        acc          = bus.wr_ready;
        @(negedge CLK);
        $display("write data=%02h accepted=%0b", d, acc);
    endtask

    task automatic test_reset();
        int base;
        RST_N        = 1'b0;
        model_en     = 1'b0;
        force_val    = 1'b1;
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'h00;
        repeat (3) @(negedge CLK);
        checks++; if (bus.tx_send !== 1'b0) begin errors++; $display("FAIL reset_tx_send: got %b expected 0", bus.tx_send); end
        checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", bus.tx_data); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
        checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b expected 1", bus.wr_ready); end
`ifdef UART_TX_QUEUE_LEVEL_EN
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
        checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf_sticky); end
`endif
        RST_N = 1'b1;
        base  = log_q.size();
        repeat (100) @(negedge CLK);
        checks++; if (log_q.size() != base) begin errors++; $display("FAIL reset_no_strobe: got %0d strobes expected 0", log_q.size() - base); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b expected 1", idle); end
    endtask

    task automatic test_single_byte();
        int base;
        bit acc;
        bit ok;
        frame_len = 200;
        model_en  = 1'b1;
        base      = log_q.size();
        @(negedge CLK);
        drive_wr(8'hA5, acc);
        bus.wr_valid = 1'b0;
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL single_accept: got %b expected 1", acc); end
        checks++; if (bus.tx_send !== 1'b0) begin errors++; $display("FAIL single_early_strobe: got %b expected 0", bus.tx_send); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty_after_write: got %b expected 0", empty); end
        @(negedge CLK);
        checks++; if (bus.tx_send !== 1'b1) begin errors++; $display("FAIL single_latency: got tx_send=%b expected 1", bus.tx_send); end
        checks++; if (bus.tx_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h expected a5", bus.tx_data); end
        @(negedge CLK);
        checks++; if (bus.tx_send !== 1'b0) begin errors++; $display("FAIL single_width: got %b expected 0", bus.tx_send); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_after_pop: got %b expected 1", empty); end
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (idle === 1'b1) begin ok = 1'b1; break; end
        end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_idle_timeout: idle=%b expected 1 within 400 cycles", idle); end
        checks++; if (log_q.size() != base + 1) begin errors++; $display("FAIL single_count: got %0d strobes expected 1", log_q.size() - base); end
        checks++; if (log_q.size() > base && log_q[base] !== 8'hA5) begin errors++; $display("FAIL single_logged: got %h expected a5", log_q[base]); end
        checks++; if (width_err != 0) begin errors++; $display("FAIL single_strobe_width: got %0d wide strobes expected 0", width_err); end
    endtask

    task automatic test_fill_full();
        int  base;
        int  n_acc;
        bit  acc;
        bit  last_acc;
        bit  full_before;
        model_en  = 1'b0;
        force_val = 1'b0;
        repeat (3) @(negedge CLK);
        base     = log_q.size();
        n_acc    = 0;
        last_acc = 1'b1;
        full_before = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i == 16) full_before = full;
            drive_wr(8'(i), acc);
            if (i < 16) n_acc += int'(acc);
            else        last_acc = acc;
        end
        bus.wr_valid = 1'b0;
        checks++; if (n_acc != 16) begin errors++; $display("FAIL fill_accepted: got %0d expected 16", n_acc); end
        checks++; if (full_before !== 1'b1) begin errors++; $display("FAIL fill_full_after_16: got %b expected 1", full_before); end
        checks++; if (last_acc !== 1'b0) begin errors++; $display("FAIL fill_17th_refused: got %b expected 0", last_acc); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b expected 1", full); end
        checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL fill_wr_ready: got %b expected 0", bus.wr_ready); end
        checks++; if (log_q.size() != base) begin errors++; $display("FAIL fill_no_strobe: got %0d strobes expected 0", log_q.size() - base); end
`ifdef UART_TX_QUEUE_LEVEL_EN
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL fill_level: got %0d expected 16", level); end
        checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL fill_ovf: got %b expected 1", ovf_sticky); end
`endif
    endtask

    task automatic test_write_pop_full();
        // Queue holds 00..0f, FSM in IDLE, tx_ready low.
        force_val    = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h10;
        checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL wp_refused_n0: got %b expected 0", bus.wr_ready); end
        @(negedge CLK);
        checks++; if (bus.tx_send !== 1'b0) begin errors++; $display("FAIL wp_no_issue_yet: got %b expected 0", bus.tx_send); end
        checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL wp_refused_n1: got %b expected 0", bus.wr_ready); end
        @(negedge CLK);
        checks++; if (bus.tx_send !== 1'b1) begin errors++; $display("FAIL wp_issue: got %b expected 1", bus.tx_send); end
        checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL wp_issue_data: got %h expected 00", bus.tx_data); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL wp_full_after_pop: got %b expected 0", full); end
        checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL wp_ready_after_pop: got %b expected 1", bus.wr_ready); end
`ifdef UART_TX_QUEUE_LEVEL_EN
        checks++; if (level !== 5'd15) begin errors++; $display("FAIL wp_level_15: got %0d expected 15", level); end
`endif
        @(negedge CLK);
        bus.wr_valid = 1'b0;
        $display("write data=10 accepted after pop");
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL wp_next_write_accepted: full=%b expected 1", full); end
        checks++; if (bus.tx_send !== 1'b0) begin errors++; $display("FAIL wp_strobe_one_cycle: got %b expected 0", bus.tx_send); end
        // Let the FSM see the transmitter go busy so it parks in WAIT_DONE.
        force_val = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_drain_wrap();
        int base;
        int n_acc;
        bit acc;
        bit ok;
        logic [7:0] exp;
        base      = log_q.size();
        frame_len = 20;
        model_en  = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge CLK);
            if (log_q.size() >= base + 8) begin ok = 1'b1; break; end
        end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL drain_first8_timeout: got %0d strobes expected 8", log_q.size() - base); end
        n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            drive_wr(8'h20 + 8'(i), acc);
            n_acc += int'(acc);
        end
        bus.wr_valid = 1'b0;
        checks++; if (n_acc != 8) begin errors++; $display("FAIL drain_mid_writes: got %0d accepted expected 8", n_acc); end
        ok = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge CLK);
            if (log_q.size() >= base + 24 && idle === 1'b1) begin ok = 1'b1; break; end
        end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL drain_done_timeout: got %0d strobes idle=%b expected 24 and idle", log_q.size() - base, idle); end
        checks++; if (log_q.size() != base + 24) begin errors++; $display("FAIL drain_count: got %0d strobes expected 24", log_q.size() - base); end
        for (int i = 0; i < 24; i++) begin
            if (i < 15)       exp = 8'h01 + 8'(i);
            else if (i == 15) exp = 8'h10;
            else              exp = 8'h20 + 8'(i - 16);
            if (base + i < log_q.size()) begin
                checks++;
                if (log_q[base + i] !== exp) begin errors++; $display("FAIL drain_order[%0d]: got %h expected %h", i, log_q[base + i], exp); end
            end
        end
        checks++; if (dbl_err != 0) begin errors++; $display("FAIL drain_double_strobe: got %0d expected 0", dbl_err); end
        checks++; if (width_err != 0) begin errors++; $display("FAIL drain_strobe_width: got %0d expected 0", width_err); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b expected 1", empty); end
    endtask

    task automatic test_reset_mid_drain();
        int base;
        bit acc;
        bit ok;
        frame_len = 60;
        base      = log_q.size();
        @(negedge CLK);
        for (int i = 0; i < 6; i++) begin
            drive_wr(8'h30 + 8'(i), acc);
        end
        bus.wr_valid = 1'b0;
        repeat (10) @(negedge CLK);
        checks++; if (log_q.size() != base + 1) begin errors++; $display("FAIL rmd_one_in_flight: got %0d strobes expected 1", log_q.size() - base); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL rmd_queued: empty=%b expected 0", empty); end
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rmd_empty: got %b expected 1", empty); end
        checks++; if (bus.tx_send !== 1'b0) begin errors++; $display("FAIL rmd_tx_send: got %b expected 0", bus.tx_send); end
        checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL rmd_tx_data: got %h expected 00", bus.tx_data); end
`ifdef UART_TX_QUEUE_LEVEL_EN
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL rmd_level: got %0d expected 0", level); end
        checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL rmd_ovf_cleared: got %b expected 0", ovf_sticky); end
`endif
        RST_N = 1'b1;
        repeat (150) @(negedge CLK);
        checks++; if (log_q.size() != base + 1) begin errors++; $display("FAIL rmd_no_strobe_after_reset: got %0d strobes expected 1", log_q.size() - base); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rmd_idle: got %b expected 1", idle); end
        drive_wr(8'h5A, acc);
        bus.wr_valid = 1'b0;
        repeat (3) @(negedge CLK);
        checks++; if (log_q.size() != base + 2) begin errors++; $display("FAIL rmd_new_write_strobe: got %0d strobes expected 2", log_q.size() - base); end
        checks++; if (log_q.size() >= base + 2 && log_q[base + 1] !== 8'h5A) begin errors++; $display("FAIL rmd_new_data: got %h expected 5a", log_q[base + 1]); end
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (idle === 1'b1) begin ok = 1'b1; break; end
        end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rmd_final_idle: idle=%b expected 1 within 300 cycles", idle); end
    endtask

    initial begin : main
        test_reset();
        test_single_byte();
        test_fill_full();
        test_write_pop_full();
        test_drain_wrap();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
